pour_seq: RTL and testbench
===========================

POUR_SEQ -- requirements
Module: pour_seq

Interface
REQ-001 Parameter UNIT_TICKS, default 100, is the number of tick pulses per pour unit, legal range 1..65535.
REQ-002 Port clk, input, 1 bit, is the single system clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit, is the asynchronous, active-low reset.
REQ-004 Port tick, input, 1 bit, is a single-cycle timing enable from the clock divider.
REQ-005 Port sel_pulse, input, 1 bit, is a single-cycle debounced one-pulse that advances the recipe selection.
REQ-006 Port start_pulse, input, 1 bit, is a single-cycle debounced one-pulse that starts a pour.
REQ-007 Port abort_pulse, input, 1 bit, is a single-cycle debounced one-pulse that stops a pour (see Configuration).
REQ-008 Port recipe, output, 2 bits, is the currently selected recipe, 0..3.
REQ-009 Port pump, output, 4 bits, is the one-hot pump drive; bit i drives pump i.
REQ-010 Port busy, output, 1 bit, is high while a pour is in progress.
REQ-011 Port done, output, 1 bit, is a single-cycle pulse on normal completion.

Function
REQ-012 The recipe table is fixed, in units, ordered pump0..pump3: R0 = 3,2,0,1; R1 = 0,4,4,0; R2 = 5,0,0,0; R3 = 1,1,1,1.
REQ-013 States: IDLE, POUR, ADV, DONE.
- Per-pour registers: 2-bit pump index idx, 16-bit tick counter, 4-bit unit counter.
REQ-014 IDLE, sel_pulse=1, start_pulse=0:
- recipe advances 0->1->2->3->0 (wraps) on the next edge.
REQ-015 IDLE, start_pulse=1:
- Next edge: state POUR, idx=0, counters cleared, busy=1.
- sel_pulse in the same cycle is ignored.
REQ-016 POUR, duration of pump idx nonzero:
- pump = one-hot(idx).
- Tick counter increments on each tick; at UNIT_TICKS it clears and the unit counter increments.
- When unit counter equals the duration, the next edge goes to ADV with pump=0.
REQ-017 POUR, duration of pump idx zero:
- pump=0; the next edge goes to ADV (one-cycle skip).
REQ-018 ADV:
- If idx<3: idx increments, counters clear, next state POUR.
- If idx=3: next state DONE.
REQ-019 DONE lasts exactly one cycle: done=1, busy=1, pump=0, then IDLE with busy=0.
REQ-020 Durations are measured in tick pulses, not clk cycles.
- A pump is on for exactly duration*UNIT_TICKS ticks, +0/+1 tick of phase alignment at entry.
REQ-021 At most one pump bit is high in any cycle.
- pump is 0 in IDLE, ADV and DONE.
REQ-022 While busy=1, sel_pulse and start_pulse are ignored and recipe is held.
REQ-023 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-024 rst=0 asynchronously forces: state IDLE, recipe=0, pump=0, busy=0, done=0, idx=0, counters=0.
- This holds mid-pour: pumps drop immediately, with no done pulse.
REQ-025 After rst deasserts, the first clk edge is a normal IDLE cycle.

Configuration
REQ-026 Macro POUR_SEQ_ABORT_EN:
- When defined: abort_pulse=1 in POUR, ADV or DONE forces IDLE on the next edge with pump=0, busy=0, done=0, and recipe unchanged.
- Abort has priority over every other event in the same cycle; abort_pulse in IDLE has no effect.
REQ-027 When POUR_SEQ_ABORT_EN is undefined, the abort_pulse port remains present but is ignored entirely.

Verification
REQ-028 Reset then four sel_pulses -> recipe = 1,2,3,0; pump=0 and busy=0 throughout.
REQ-029 UNIT_TICKS=2, tick every cycle, R0, start:
- pump=0001 for 6 ticks, then 0 for 1 cycle (ADV), then 0010 for 4 ticks.
- Then a 1-cycle skip of pump2 plus ADV cycles, then 1000 for 2 ticks, then done pulse; busy drops the next cycle.
REQ-030 R2 with tick every 4th cycle, UNIT_TICKS=2 -> pump=0001 for 10 ticks (~40 cycles), pumps 1..3 skipped, one done pulse.
REQ-031 start_pulse and sel_pulse in the same IDLE cycle -> pour starts with the old recipe; recipe does not change; start_pulse mid-pour -> no restart.
REQ-032 rst=0 during pump1 of R1 -> pump=0 and busy=0 the same cycle without waiting for clk; recipe=0; done never asserted.
REQ-033 POUR_SEQ_ABORT_EN defined, abort_pulse during R3 pump2 -> pump=0, busy=0 next edge, no done, recipe=3; undefined -> pour completes normally with done.

Source files
------------

// File: rtl/pour_seq.sv
// pour_seq: recipe-driven four-pump pour sequencer timed by tick pulses
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   tick         single-cycle timing enable
//   sel_pulse    advance recipe selection (idle only)
//   start_pulse  start a pour (idle only)
//   abort_pulse  stop a pour; honoured only when POUR_SEQ_ABORT_EN is defined
//   recipe       selected recipe 0..3
//   pump         one-hot pump drive
//   busy         pour in progress
//   done         one-cycle pulse on normal completion
// Parameter UNIT_TICKS: tick pulses per pour unit (1..65535).
module pour_seq #(
  parameter int UNIT_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sel_pulse,
  input  logic       start_pulse,
  input  logic       abort_pulse,
  output logic [1:0] recipe,
  output logic [3:0] pump,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, POUR, ADV, DONE} state_t;
  localparam logic [15:0] UT_M1 = 16'(UNIT_TICKS - 1);
  // durations in units, nibble index {recipe, pump}
  localparam logic [63:0] TABLE = {4'd1, 4'd1, 4'd1, 4'd1,
                                   4'd0, 4'd0, 4'd0, 4'd5,
                                   4'd0, 4'd4, 4'd4, 4'd0,
                                   4'd1, 4'd0, 4'd2, 4'd3};
  state_t state, state_n;
  logic [1:0] recipe_n, idx, idx_n;
  logic [15:0] tcnt, tcnt_n;
  logic [3:0] ucnt, ucnt_n, dur, dur_n, pump_n;
  logic unit_end;
  assign dur = TABLE[{recipe, idx, 2'b00} +: 4];
  assign dur_n = TABLE[{recipe_n, idx_n, 2'b00} +: 4];
  assign unit_end = tick && tcnt == UT_M1;
`ifndef POUR_SEQ_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort_pulse;
`endif
  always_comb begin
    state_n = state;
    recipe_n = recipe;
    idx_n = idx;
    tcnt_n = tcnt;
    ucnt_n = ucnt;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          state_n = POUR;
          idx_n = '0;
          tcnt_n = '0;
          ucnt_n = '0;
        end else if (sel_pulse) begin
          recipe_n = recipe + 2'd1;
        end
      end
      POUR: begin
        if (dur == '0) begin
          state_n = ADV;
        end else if (tick) begin
          tcnt_n = unit_end ? '0 : tcnt + 16'd1;
          ucnt_n = unit_end ? ucnt + 4'd1 : ucnt;
          // leave on the very tick that completes the last unit so the pump
          // is on for exactly duration*UNIT_TICKS ticks
          if (unit_end && ucnt + 4'd1 == dur) state_n = ADV;
        end
      end
      ADV: begin
        state_n = idx == 2'd3 ? DONE : POUR;
        idx_n = idx == 2'd3 ? idx : idx + 2'd1;
        tcnt_n = '0;
        ucnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n = '0;
        tcnt_n = '0;
        ucnt_n = '0;
      end
    endcase
`ifdef POUR_SEQ_ABORT_EN
    if (abort_pulse && state != IDLE) begin
      state_n = IDLE;
      recipe_n = recipe;
      idx_n = '0;
      tcnt_n = '0;
      ucnt_n = '0;
    end
`endif
    // outputs are registered from next-state values
    pump_n = (state_n == POUR && dur_n != '0) ? 4'b0001 << idx_n : 4'b0000;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      recipe <= '0;
      idx <= '0;
      tcnt <= '0;
      ucnt <= '0;
      pump <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      recipe <= recipe_n;
      idx <= idx_n;
      tcnt <= tcnt_n;
      ucnt <= ucnt_n;
      pump <= pump_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_pour_seq.sv
// tb_pour_seq: randomized self-checking bench for pour_seq against a trace-level model
module tb_pour_seq;
  localparam int UT = 2;
  logic clk = 0, rst = 0, tick = 0, sel_pulse = 0, start_pulse = 0, abort_pulse = 0;
  logic [1:0] recipe;
  logic [3:0] pump;
  logic busy, done;
  int passes = 0, total = 0, model_recipe = 0;
  bit abort_en;
  int dur_tab [4][4] = '{'{3, 2, 0, 1}, '{0, 4, 4, 0}, '{5, 0, 0, 0}, '{1, 1, 1, 1}};

  pour_seq #(.UNIT_TICKS(UT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .sel_pulse(sel_pulse),
    .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .recipe(recipe), .pump(pump), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".pump"}, pump, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".recipe"}, recipe, model_recipe);
  endtask

  task automatic sel();
    sel_pulse = 1;
    abort_pulse = 1'($urandom % 2);
    step();
    sel_pulse = 0;
    abort_pulse = 0;
    model_recipe = (model_recipe + 1) % 4;
    check_idle("sel");
  endtask

  task automatic select(input int r);
    while (model_recipe != r) sel();
  endtask

  // mode 0: tick every cycle, 1: every 4th cycle, 2: random
  task automatic run_pour(input int mode, input bit sel_too, input int abort_at,
                          input int rst_at, input bit noise);
    bit tk [512];
    logic [3:0] ep [512];
    bit ed [512];
    int c = 0, n, need;
    for (int k = 0; k < 512; k++) begin
      tk[k] = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 3) : ($urandom % 2 == 1 || k % 8 == 7);
      ep[k] = 0;
      ed[k] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (dur_tab[model_recipe][i] == 0) c++;
      else begin
        need = dur_tab[model_recipe][i] * UT;
        while (need > 0) begin
          ep[c] = 4'(1 << i);
          if (tk[c]) need--;
          c++;
        end
      end
      c++;
    end
    ed[c] = 1;
    n = c + 1;
    if (abort_en && abort_at >= 0 && abort_at < n) n = abort_at + 1;
    start_pulse = 1;
    sel_pulse = sel_too;
    tick = 1'($urandom % 2);
    step();
    start_pulse = 0;
    sel_pulse = 0;
    for (int k = 0; k < n; k++) begin
      check("pour.pump", pump, ep[k]);
      check("pour.busy", busy, 1);
      check("pour.done", done, ed[k]);
      check("pour.recipe", recipe, model_recipe);
      if (k == rst_at) begin
        tick = 0; sel_pulse = 0; start_pulse = 0; abort_pulse = 0;
        #2 rst = 0;
        #1;
        model_recipe = 0;
        check("rst.pump", pump, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.recipe", recipe, 0);
        repeat (2) begin
          step();
          check("rst_hold.done", done, 0);
          check("rst_hold.pump", pump, 0);
        end
        @(negedge clk) rst = 1;
        step();
        check_idle("post_rst");
        return;
      end
      tick = tk[k];
      abort_pulse = (k == abort_at);
      if (noise) begin
        sel_pulse = ($urandom % 3 == 0);
        start_pulse = ($urandom % 3 == 0);
      end
      step();
    end
    tick = 0; abort_pulse = 0; sel_pulse = 0; start_pulse = 0;
    check_idle("after_pour");
  endtask

  initial begin
`ifdef POUR_SEQ_ABORT_EN
    abort_en = 1;
`else
    abort_en = 0;
`endif
    #12;
    check_idle("reset");
    @(negedge clk) rst = 1;
    step();
    check_idle("first_idle");
    repeat (4) sel();
    select(0);
    run_pour(0, 0, -1, -1, 0);
    select(2);
    run_pour(1, 0, -1, -1, 0);
    select(1);
    run_pour(2, 1, -1, -1, 1);
    select(3);
    run_pour(0, 0, 6, -1, 0);
    for (int j = 0; j < 12; j++) begin
      select(int'($urandom % 4));
      run_pour(int'($urandom % 3), 1'($urandom % 2),
               ($urandom % 4 == 0) ? int'($urandom % 20) : -1, -1, 1);
    end
    select(1);
    run_pour(0, 0, -1, 4, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
